rx_packet_ctrl: RTL and testbench
=================================

RX_PACKET_CTRL -- requirements
Module: rx_packet_ctrl

Interface
REQ-001 SHALL have ports: clk in 1, system clock, all logic on rising edge.
REQ-002 SHALL have ports: n_rst in 1, reset, asynchronous, active-low.
REQ-003 SHALL have inputs from usb_rx: rx_packet in 3 (PID class); packet_done in 1 (1-cycle EOP pulse); r_error in 1 (level); store_rx_packet in 1 (FIFO write strobe).
REQ-004 SHALL have inputs from the RX FIFO: fifo_empty in 1; fifo_full in 1; fifo_r_data in 8 (valid the cycle after fifo_r_enable).
REQ-005 SHALL have host-side inputs: host_read in 1 (request one byte); host_clear in 1 (discard packet/status).
REQ-006 SHALL have outputs: fifo_r_enable out 1; host_data out 8; host_valid out 1; data_ready out 1; byte_count out 7; pkt_type out 3; rx_err out 1; overflow out 1; busy out 1.
REQ-007 rx_packet encodings SHALL be 0 none, 1 OUT, 2 IN, 3 DATA, 4 ACK, 5 NAK, 6 STALL, 7 reserved.

Function
REQ-008 SHALL implement FSM states IDLE, RECV, READY, RD_ISSUE, RD_CAPT, FLUSH, ERROR.
REQ-009 IDLE->RECV on first store_rx_packet; IDLE->READY on packet_done with non-DATA pkt and r_error=0 (byte_count stays 0).
REQ-010 In RECV, each store_rx_packet SHALL increment byte_count, saturating at 64.
REQ-011 RECV->READY on packet_done with r_error=0; pkt_type SHALL latch rx_packet on that packet_done.
REQ-012 r_error=1 in IDLE/RECV, or packet_done coincident with r_error=1, SHALL go to FLUSH and set rx_err; error wins over a simultaneous packet_done.
REQ-013 store_rx_packet while fifo_full=1 SHALL set overflow and go to FLUSH; byte_count not incremented.
REQ-014 data_ready SHALL be 1 exactly in READY, RD_ISSUE, RD_CAPT.
REQ-015 In READY, host_read with byte_count>0 and fifo_empty=0 SHALL go RD_ISSUE: fifo_r_enable=1 for exactly one cycle.
REQ-016 RD_ISSUE->RD_CAPT unconditionally; in RD_CAPT host_data SHALL register fifo_r_data, host_valid=1 the following cycle for one cycle, byte_count decrements by 1, return to READY.
REQ-017 Read latency: host_read sampled at edge N -> host_valid high in cycle N+3.
REQ-018 host_read outside READY, or with byte_count=0, SHALL be ignored (no FIFO read, no host_valid).
REQ-019 READY with byte_count=0 and host_clear=1 SHALL return to IDLE, clearing pkt_type to 0.
REQ-020 host_clear in READY with byte_count>0 SHALL go to FLUSH.
REQ-021 FLUSH SHALL assert fifo_r_enable every cycle while fifo_empty=0; on fifo_empty=1 go to ERROR if rx_err or overflow set, else IDLE; byte_count cleared to 0 on exit.
REQ-022 ERROR SHALL hold rx_err/overflow until host_clear=1, then go to IDLE clearing both flags.
REQ-023 store_rx_packet/packet_done in READY, RD_*, FLUSH, ERROR SHALL set overflow (unread packet lost) and not disturb the current read; FSM then enters FLUSH after any RD_CAPT completes.
REQ-024 busy SHALL be 1 in every state except IDLE and READY.
REQ-025 fifo_r_enable SHALL never assert while fifo_empty=1.

Reset
REQ-026 On n_rst=0 all state SHALL clear asynchronously: FSM IDLE; host_data 0; byte_count 0; pkt_type 0; all 1-bit outputs 0.
REQ-027 Reset mid-read or mid-flush SHALL abort immediately; no fifo_r_enable pulse after n_rst falls.

Verification
REQ-028 Reset: assert n_rst=0 during RECV -> all outputs 0, FSM IDLE next cycle after release.
REQ-029 Nominal DATA: 4 store_rx_packet (0x07,0x01,0x02,0x03 in FIFO), packet_done, rx_packet=3 -> data_ready=1, pkt_type=3, byte_count=4; 4 host_reads -> host_data 0x07,0x01,0x02,0x03, each host_valid 3 cycles after request; byte_count 0.
REQ-030 Token/handshake: packet_done with rx_packet=4, no stores -> READY, byte_count=0, pkt_type=4; host_read ignored; host_clear -> IDLE.
REQ-031 Error: 2 stores then r_error=1 with packet_done -> FLUSH drains 2 bytes (2 fifo_r_enable pulses), ERROR, rx_err=1, data_ready=0; host_clear -> IDLE, rx_err=0.
REQ-032 Overflow: store_rx_packet with fifo_full=1 -> overflow=1, FLUSH until fifo_empty, ERROR.
REQ-033 Discard: READY with byte_count=3, host_clear -> FLUSH 3 reads, IDLE, byte_count=0, rx_err=0.

Source files
------------

// File: rtl/rx_packet_ctrl_if.sv
// Bus bundle between the USB receive path, the RX FIFO, the host side and
// the receive packet controller.
//
// Handshake semantics:
//   - store_rx_packet is a one-cycle write strobe; packet_done is a one-cycle
//     end-of-packet pulse; r_error is a level.
//   - fifo_r_enable pops exactly one byte per cycle it is high and is never
//     high while fifo_empty is high; the popped byte appears on fifo_r_data
//     the cycle after the pop.
//   - host_read is a request that is accepted only while a packet is ready
//     with bytes remaining; an accepted request is answered by host_valid,
//     a one-cycle pulse qualifying host_data, with no backpressure.
//   - host_clear is a one-cycle request to discard the current packet/status.
interface rx_packet_ctrl_if;
  // usb_rx side
  logic [2:0] rx_packet;
  logic       packet_done;
  logic       r_error;
  logic       store_rx_packet;
  // RX FIFO side
  logic       fifo_empty;
  logic       fifo_full;
  logic [7:0] fifo_r_data;
  logic       fifo_r_enable;
  // host side
  logic       host_read;
  logic       host_clear;
  logic [7:0] host_data;
  logic       host_valid;
  logic       data_ready;
  logic [6:0] byte_count;
  logic [2:0] pkt_type;
  logic       rx_err;
  logic       overflow;
  logic       busy;
  // controller state, for observation only
  logic [2:0] state_dbg;

  // Environment side: USB receiver, FIFO and host.
  modport master (
    output rx_packet, packet_done, r_error, store_rx_packet,
    output fifo_empty, fifo_full, fifo_r_data,
    output host_read, host_clear,
    input  fifo_r_enable, host_data, host_valid, data_ready, byte_count,
    input  pkt_type, rx_err, overflow, busy, state_dbg
  );

  // Controller side.
  modport slave (
    input  rx_packet, packet_done, r_error, store_rx_packet,
    input  fifo_empty, fifo_full, fifo_r_data,
    input  host_read, host_clear,
    output fifo_r_enable, host_data, host_valid, data_ready, byte_count,
    output pkt_type, rx_err, overflow, busy, state_dbg
  );
endinterface

// File: rtl/rx_packet_ctrl.sv
// Receive packet controller: counts bytes of an incoming USB packet as they
// are stored in the RX FIFO, presents the finished packet to the host, hands
// out bytes one at a time on request, and drains the FIFO when a packet is
// discarded, errored or overrun.
module rx_packet_ctrl (
  input logic           clk,
  input logic           n_rst,
  rx_packet_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RECV     = 3'd1,
    READY    = 3'd2,
    RD_ISSUE = 3'd3,
    RD_CAPT  = 3'd4,
    FLUSH    = 3'd5,
    ERROR    = 3'd6
  } state_t;

  localparam logic [2:0] PID_DATA  = 3'd3;
  localparam logic [6:0] MAX_COUNT = 7'd64;

  state_t     state;
  logic [7:0] host_data_q;
  logic       host_valid_q;
  logic [6:0] byte_count_q;
  logic [2:0] pkt_type_q;
  logic       rx_err_q;
  logic       overflow_q;

  // Any receive activity arriving while a packet is still held by the host
  // means a new packet is being lost.
  logic late_event;
  assign late_event = bus.store_rx_packet | bus.packet_done;

  // Main controller: state plus every registered output.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= IDLE;
      host_data_q  <= 8'd0;
      host_valid_q <= 1'b0;
      byte_count_q <= 7'd0;
      pkt_type_q   <= 3'd0;
      rx_err_q     <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      host_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.r_error) begin
            rx_err_q <= 1'b1;
            state    <= FLUSH;
          end else if (bus.store_rx_packet) begin
            if (bus.fifo_full) begin
              overflow_q <= 1'b1;
              state      <= FLUSH;
            end else begin
              byte_count_q <= 7'd1;
              // A one-byte packet whose EOP coincides with its only byte.
              if (bus.packet_done) begin
                pkt_type_q <= bus.rx_packet;
                state      <= READY;
              end else begin
                state <= RECV;
              end
            end
          end else if (bus.packet_done && (bus.rx_packet != PID_DATA)) begin
            // Token/handshake packet: nothing stored, report type only.
            pkt_type_q <= bus.rx_packet;
            state      <= READY;
          end
        end

        RECV: begin
          // Error outranks both the store and the EOP in the same cycle.
          if (bus.r_error) begin
            rx_err_q <= 1'b1;
            state    <= FLUSH;
          end else if (bus.store_rx_packet && bus.fifo_full) begin
            overflow_q <= 1'b1;
            state      <= FLUSH;
          end else begin
            if (bus.store_rx_packet && (byte_count_q < MAX_COUNT)) begin
              byte_count_q <= byte_count_q + 7'd1;
            end
            if (bus.packet_done) begin
              pkt_type_q <= bus.rx_packet;
              state      <= READY;
            end
          end
        end

        READY: begin
          if (late_event) begin
            overflow_q <= 1'b1;
            state      <= FLUSH;
          end else if (bus.host_clear) begin
            if (byte_count_q == 7'd0) begin
              pkt_type_q <= 3'd0;
              state      <= IDLE;
            end else begin
              state <= FLUSH;
            end
          end else if (bus.host_read && (byte_count_q != 7'd0) && !bus.fifo_empty) begin
            state <= RD_ISSUE;
          end
        end

        RD_ISSUE: begin
          // The pop is already under way; a lost packet is only recorded.
          if (late_event) begin
            overflow_q <= 1'b1;
          end
          state <= RD_CAPT;
        end

        RD_CAPT: begin
          host_data_q  <= bus.fifo_r_data;
          host_valid_q <= 1'b1;
          if (byte_count_q != 7'd0) begin
            byte_count_q <= byte_count_q - 7'd1;
          end
          if (late_event) begin
            overflow_q <= 1'b1;
          end
          // Finish this byte, then drain if a packet was lost meanwhile.
          if (overflow_q || late_event) begin
            state <= FLUSH;
          end else begin
            state <= READY;
          end
        end

        FLUSH: begin
          if (late_event) begin
            overflow_q <= 1'b1;
          end
          if (bus.fifo_empty) begin
            byte_count_q <= 7'd0;
            pkt_type_q   <= 3'd0;
            if (rx_err_q || overflow_q || late_event) begin
              state <= ERROR;
            end else begin
              state <= IDLE;
            end
          end
        end

        ERROR: begin
          if (bus.host_clear) begin
            rx_err_q   <= 1'b0;
            overflow_q <= 1'b0;
            state      <= IDLE;
          end else if (late_event) begin
            overflow_q <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // FIFO pop: one cycle in RD_ISSUE, every non-empty cycle in FLUSH. Decoded
  // from the registered state and gated by fifo_empty so that the final pop
  // of a drain can never be followed by a pop of an empty FIFO; reset forces
  // IDLE and so drops it at once.
  assign bus.fifo_r_enable = ((state == RD_ISSUE) || (state == FLUSH)) && !bus.fifo_empty;

  assign bus.host_data  = host_data_q;
  assign bus.host_valid = host_valid_q;
  assign bus.byte_count = byte_count_q;
  assign bus.pkt_type   = pkt_type_q;
  assign bus.rx_err     = rx_err_q;
  assign bus.overflow   = overflow_q;
  assign bus.data_ready = (state == READY) || (state == RD_ISSUE) || (state == RD_CAPT);
  assign bus.busy       = (state != IDLE) && (state != READY);
  assign bus.state_dbg  = state;

endmodule

// File: tb/tb_rx_packet_ctrl.sv
// Directed bench for rx_packet_ctrl with a behavioural RX FIFO.
module tb_rx_packet_ctrl;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RECV     = 3'd1;
  localparam logic [2:0] S_READY    = 3'd2;
  localparam logic [2:0] S_RD_ISSUE = 3'd3;
  localparam logic [2:0] S_RD_CAPT  = 3'd4;
  localparam logic [2:0] S_FLUSH    = 3'd5;
  localparam logic [2:0] S_ERROR    = 3'd6;

  // clock / reset
  logic tb_clk;
  logic tb_n_rst;
  initial tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  int n_checks = 0;
  int n_errors = 0;

  rx_packet_ctrl_if bus();

  rx_packet_ctrl dut (
    .clk   (tb_clk),
    .n_rst (tb_n_rst),
    .bus   (bus.slave)
  );

  // behavioural RX FIFO: 128 deep, read data valid the cycle after a pop
  logic [7:0] fifo_mem [128];
  logic [6:0] wp;
  logic [6:0] rp;
  logic [7:0] fcnt;
  logic [7:0] rd_data;
  logic [7:0] wr_byte;
  logic       force_full;
  logic       fifo_clr;
  logic       push;
  logic       pop;

  assign push            = bus.store_rx_packet && !force_full;
  assign pop             = bus.fifo_r_enable && (fcnt != 8'd0);
  assign bus.fifo_empty  = (fcnt == 8'd0);
  assign bus.fifo_full   = force_full;
  assign bus.fifo_r_data = rd_data;

  always @(posedge tb_clk) begin
    if (fifo_clr) begin
      wp      <= 7'd0;
      rp      <= 7'd0;
      fcnt    <= 8'd0;
      rd_data <= 8'd0;
    end else begin
      if (push) begin
        fifo_mem[wp] <= wr_byte;
        wp <= wp + 7'd1;
      end
      if (pop) begin
        rd_data <= fifo_mem[rp];
        rp <= rp + 7'd1;
      end
      fcnt <= fcnt + {7'd0, push} - {7'd0, pop};
    end
  end

  // event counters sampled mid-cycle
  int ren_cnt = 0;
  int hv_cnt = 0;
  int ren_empty_viol = 0;
  always @(negedge tb_clk) begin
    if (bus.fifo_r_enable) ren_cnt++;
    if (bus.host_valid) hv_cnt++;
    if (bus.fifo_r_enable && bus.fifo_empty) ren_empty_viol++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks: inputs change on the falling edge only
  task automatic tick();
    @(negedge tb_clk);
  endtask

  task automatic store_byte(input logic [7:0] b);
    bus.store_rx_packet = 1'b1;
    wr_byte = b;
    tick();
    bus.store_rx_packet = 1'b0;
  endtask

  task automatic pkt_done(input logic [2:0] pid, input logic err);
    bus.packet_done = 1'b1;
    bus.rx_packet = pid;
    bus.r_error = err;
    tick();
    bus.packet_done = 1'b0;
    bus.rx_packet = 3'd0;
    bus.r_error = 1'b0;
  endtask

  task automatic clear_pulse();
    bus.host_clear = 1'b1;
    tick();
    bus.host_clear = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int bound, input string tag);
    for (int i = 0; i < bound; i++) begin
      if (bus.state_dbg == s) break;
      tick();
    end
    chk(tag, bus.state_dbg, s);
  endtask

  task automatic do_read(input logic [7:0] exp, input logic [6:0] exp_cnt);
    bus.host_read = 1'b1;
    tick();
    bus.host_read = 1'b0;
    chk("rd_issue_state", bus.state_dbg, S_RD_ISSUE);
    chk("rd_issue_ren", bus.fifo_r_enable, 1);
    tick();
    chk("rd_capt_no_valid", bus.host_valid, 0);
    tick();
    chk("rd_valid", bus.host_valid, 1);
    chk("rd_data", bus.host_data, exp);
    chk("rd_count", bus.byte_count, exp_cnt);
    tick();
    chk("rd_valid_pulse", bus.host_valid, 0);
  endtask

  int ren0;
  int hv0;

  initial begin
    tb_n_rst = 1'b0;
    fifo_clr = 1'b1;
    force_full = 1'b0;
    wr_byte = 8'd0;
    bus.rx_packet = 3'd0;
    bus.packet_done = 1'b0;
    bus.r_error = 1'b0;
    bus.store_rx_packet = 1'b0;
    bus.host_read = 1'b0;
    bus.host_clear = 1'b0;
    tick();
    tick();

    // reset values
    chk("rst_state", bus.state_dbg, S_IDLE);
    chk("rst_outputs", {bus.fifo_r_enable, bus.host_valid, bus.data_ready, bus.rx_err,
                        bus.overflow, bus.busy}, 0);
    chk("rst_host_data", bus.host_data, 0);
    chk("rst_count_type", {bus.byte_count, bus.pkt_type}, 0);
    tb_n_rst = 1'b1;
    fifo_clr = 1'b0;
    tick();

    // reset asserted while receiving
    store_byte(8'h10);
    store_byte(8'h20);
    chk("recv_state", bus.state_dbg, S_RECV);
    chk("recv_count", bus.byte_count, 2);
    chk("recv_busy", bus.busy, 1);
    #2 tb_n_rst = 1'b0;
    #1;
    chk("async_rst_state", bus.state_dbg, S_IDLE);
    chk("async_rst_outputs", {bus.byte_count, bus.busy, bus.fifo_r_enable, bus.data_ready}, 0);
    fifo_clr = 1'b1;
    tick();
    tick();
    tb_n_rst = 1'b1;
    fifo_clr = 1'b0;
    tick();
    chk("post_rst_idle", bus.state_dbg, S_IDLE);

    // nominal DATA packet
    store_byte(8'h07);
    store_byte(8'h01);
    store_byte(8'h02);
    store_byte(8'h03);
    pkt_done(3'd3, 1'b0);
    chk("data_ready", bus.data_ready, 1);
    chk("data_pkt_type", bus.pkt_type, 3);
    chk("data_count", bus.byte_count, 4);
    chk("data_not_busy", bus.busy, 0);
    do_read(8'h07, 7'd3);
    do_read(8'h01, 7'd2);
    do_read(8'h02, 7'd1);
    do_read(8'h03, 7'd0);
    ren0 = ren_cnt;
    hv0 = hv_cnt;
    bus.host_read = 1'b1;
    tick();
    bus.host_read = 1'b0;
    tick();
    tick();
    tick();
    chk("empty_read_no_pop", ren_cnt - ren0, 0);
    chk("empty_read_no_valid", hv_cnt - hv0, 0);
    chk("empty_read_state", bus.state_dbg, S_READY);
    clear_pulse();
    chk("data_clear_idle", bus.state_dbg, S_IDLE);
    chk("data_clear_type", bus.pkt_type, 0);

    // token / handshake packet
    pkt_done(3'd4, 1'b0);
    chk("ack_state", bus.state_dbg, S_READY);
    chk("ack_count_type", {bus.byte_count, bus.pkt_type}, {7'd0, 3'd4});
    ren0 = ren_cnt;
    hv0 = hv_cnt;
    bus.host_read = 1'b1;
    tick();
    bus.host_read = 1'b0;
    tick();
    tick();
    tick();
    chk("ack_read_ignored", {ren_cnt - ren0, hv_cnt - hv0}, 0);
    clear_pulse();
    chk("ack_clear_idle", bus.state_dbg, S_IDLE);
    chk("ack_clear_type", {bus.pkt_type, bus.data_ready}, 0);

    // receive error coincident with packet_done
    store_byte(8'hAA);
    store_byte(8'hBB);
    ren0 = ren_cnt;
    pkt_done(3'd3, 1'b1);
    chk("err_flush_state", bus.state_dbg, S_FLUSH);
    chk("err_flag", bus.rx_err, 1);
    chk("err_no_ready", bus.data_ready, 0);
    wait_state(S_ERROR, 10, "err_to_error");
    chk("err_drain_pops", ren_cnt - ren0, 2);
    chk("err_hold", {bus.rx_err, bus.data_ready, bus.busy}, 3'b101);
    chk("err_count", bus.byte_count, 0);
    clear_pulse();
    chk("err_clear_idle", bus.state_dbg, S_IDLE);
    chk("err_clear_flag", bus.rx_err, 0);

    // store into a full FIFO
    store_byte(8'h11);
    force_full = 1'b1;
    store_byte(8'h22);
    force_full = 1'b0;
    chk("ovf_flag", bus.overflow, 1);
    chk("ovf_state", bus.state_dbg, S_FLUSH);
    chk("ovf_count_held", bus.byte_count, 1);
    ren0 = ren_cnt;
    wait_state(S_ERROR, 10, "ovf_to_error");
    chk("ovf_drain_pops", ren_cnt - ren0, 1);
    chk("ovf_flags", {bus.overflow, bus.rx_err}, 2'b10);
    clear_pulse();
    chk("ovf_clear", {bus.state_dbg, bus.overflow}, {S_IDLE, 1'b0});

    // new packet arriving during a host read
    store_byte(8'h5A);
    store_byte(8'hC3);
    pkt_done(3'd3, 1'b0);
    ren0 = ren_cnt;
    bus.host_read = 1'b1;
    tick();
    bus.host_read = 1'b0;
    chk("late_issue", bus.state_dbg, S_RD_ISSUE);
    bus.store_rx_packet = 1'b1;
    wr_byte = 8'hEE;
    tick();
    bus.store_rx_packet = 1'b0;
    chk("late_capt", bus.state_dbg, S_RD_CAPT);
    chk("late_ovf", bus.overflow, 1);
    tick();
    chk("late_valid", bus.host_valid, 1);
    chk("late_data", bus.host_data, 8'h5A);
    chk("late_flush", bus.state_dbg, S_FLUSH);
    wait_state(S_ERROR, 10, "late_to_error");
    chk("late_pops", ren_cnt - ren0, 3);
    clear_pulse();
    chk("late_clear", {bus.state_dbg, bus.overflow}, {S_IDLE, 1'b0});

    // discard a ready packet with bytes left
    store_byte(8'h31);
    store_byte(8'h32);
    store_byte(8'h33);
    pkt_done(3'd3, 1'b0);
    chk("disc_count", bus.byte_count, 3);
    ren0 = ren_cnt;
    clear_pulse();
    chk("disc_flush", bus.state_dbg, S_FLUSH);
    wait_state(S_IDLE, 10, "disc_to_idle");
    chk("disc_pops", ren_cnt - ren0, 3);
    chk("disc_clean", {bus.byte_count, bus.rx_err, bus.overflow}, 0);

    // byte count saturates at 64
    for (int i = 0; i < 66; i++) store_byte(8'(i));
    chk("sat_count", bus.byte_count, 64);
    pkt_done(3'd3, 1'b0);
    chk("sat_ready", {bus.state_dbg, bus.byte_count}, {S_READY, 7'd64});
    ren0 = ren_cnt;
    clear_pulse();
    wait_state(S_IDLE, 100, "sat_to_idle");
    chk("sat_pops", ren_cnt - ren0, 66);

    // reset during a flush drops the pop immediately
    store_byte(8'h41);
    store_byte(8'h42);
    pkt_done(3'd3, 1'b1);
    chk("rflush_state", bus.state_dbg, S_FLUSH);
    #2 tb_n_rst = 1'b0;
    #1;
    chk("rflush_no_pop", {bus.fifo_r_enable, bus.state_dbg, bus.rx_err}, 0);
    fifo_clr = 1'b1;
    tick();
    tb_n_rst = 1'b1;
    fifo_clr = 1'b0;
    tick();

    chk("no_pop_while_empty", ren_empty_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
